ieeedrv_ram_arb: RTL and testbench

Single-port arbiter and sequencer for the 4 KiB shared buffer RAM of the IEEE drive. It serves three requesters: the DOS CPU, the controller CPU and a disk-image DMA engine. Each requester gets an ack/data handshake, so the drive can use one single-port synchronous RAM in place of a dual-port macro. The block sits between the two CPU address decoders and the RAM, and adds an image-streaming port.

---
 rtl/ieeedrv_ram_arb.sv | 238 +++++++++++++++++++++++
 tb/tb_ieeedrv_ram_arb.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ieeedrv_ram_arb.sv
// Three-port arbiter/sequencer for the IEEE drive's shared single-port buffer RAM.
// Two strobed CPU ports (A, B) with holding registers and one level-handshake DMA port.
module ieeedrv_ram_arb #(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  output logic [DW-1:0] a_dout,
  output logic          a_ack,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_din,
  output logic [DW-1:0] b_dout,
  output logic          b_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_din,
  output logic [DW-1:0] d_dout,
  output logic          d_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ovr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    G_A = 2'd0,
    G_B = 2'd1,
    G_D = 2'd2
  } gnt_t;

  state_t r_state;
  state_t w_state_nxt;
  gnt_t   r_gnt;
  gnt_t   w_sel;
  logic   r_gnt_we;

  logic          r_pend_a;
  logic          r_a_we;
  logic [AW-1:0] r_a_addr;
  logic [DW-1:0] r_a_din;
  logic          r_pend_b;
  logic          r_b_we;
  logic [AW-1:0] r_b_addr;
  logic [DW-1:0] r_b_din;

  logic [AW-1:0] r_ram_addr;
  logic          r_ram_we;
  logic [DW-1:0] r_ram_din;
  logic [DW-1:0] r_a_dout;
  logic [DW-1:0] r_b_dout;
  logic [DW-1:0] r_d_dout;
  logic          r_a_ack;
  logic          r_b_ack;
  logic          r_d_ack;
  logic          r_ovr;

  logic          w_resp;
  logic          w_done_a;
  logic          w_done_b;
  logic          w_done_d;
  logic          w_elig_a;
  logic          w_elig_b;
  logic          w_elig_d;
  logic          w_any;
  logic          w_load;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_din;

  // The owner of the access finishing this cycle is never eligible for the re-arbitration.
  assign w_resp   = (r_state == S_RESP);
  assign w_done_a = w_resp && (r_gnt == G_A);
  assign w_done_b = w_resp && (r_gnt == G_B);
  assign w_done_d = w_resp && (r_gnt == G_D);
  assign w_elig_a = r_pend_a && !w_done_a;
  assign w_elig_b = r_pend_b && !w_done_b;
  assign w_elig_d = d_req && !w_done_d;
  assign w_any    = w_elig_a || w_elig_b || w_elig_d;

  // NOTE: defaults are assigned first so no path leaves a signal unassigned (no latch).
  always_comb begin
    w_sel      = G_A;
    w_sel_we   = r_a_we;
    w_sel_addr = r_a_addr;
    w_sel_din  = r_a_din;
    if (w_elig_a) begin
      w_sel      = G_A;
      w_sel_we   = r_a_we;
      w_sel_addr = r_a_addr;
      w_sel_din  = r_a_din;
    end else if (w_elig_b) begin
      w_sel      = G_B;
      w_sel_we   = r_b_we;
      w_sel_addr = r_b_addr;
      w_sel_din  = r_b_din;
    end else begin
      w_sel      = G_D;
      w_sel_we   = d_we;
      w_sel_addr = d_addr;
      w_sel_din  = d_din;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (w_any) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ram_we is only ever high for the RUN cycle that follows a write grant.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt      <= G_A;
      r_gnt_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_we   <= 1'b0;
      r_ram_din  <= '0;
    end else if (w_load) begin
      r_gnt      <= w_sel;
      r_gnt_we   <= w_sel_we;
      r_ram_addr <= w_sel_addr;
      r_ram_we   <= w_sel_we;
      r_ram_din  <= w_sel_din;
    end else begin
      r_ram_we   <= 1'b0;
    end
  end

  // A strobe landing on the completion cycle starts a fresh request rather than overrunning.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_a <= 1'b0;
      r_a_we   <= 1'b0;
      r_a_addr <= '0;
      r_a_din  <= '0;
      r_pend_b <= 1'b0;
      r_b_we   <= 1'b0;
      r_b_addr <= '0;
      r_b_din  <= '0;
      r_ovr    <= 1'b0;
    end else begin
      if (a_req && (!r_pend_a || w_done_a)) begin
        r_pend_a <= 1'b1;
        r_a_we   <= a_we;
        r_a_addr <= a_addr;
        r_a_din  <= a_din;
      end else if (w_done_a) begin
        r_pend_a <= 1'b0;
      end
      if (b_req && (!r_pend_b || w_done_b)) begin
        r_pend_b <= 1'b1;
        r_b_we   <= b_we;
        r_b_addr <= b_addr;
        r_b_din  <= b_din;
      end else if (w_done_b) begin
        r_pend_b <= 1'b0;
      end
      if ((a_req && r_pend_a && !w_done_a) || (b_req && r_pend_b && !w_done_b)) begin
        r_ovr <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_a_ack  <= 1'b0;
      r_b_ack  <= 1'b0;
      r_d_ack  <= 1'b0;
      r_a_dout <= '0;
      r_b_dout <= '0;
      r_d_dout <= '0;
    end else begin
      r_a_ack <= w_done_a;
      r_b_ack <= w_done_b;
      r_d_ack <= w_done_d;
      if (w_done_a && !r_gnt_we) r_a_dout <= ram_dout;
      if (w_done_b && !r_gnt_we) r_b_dout <= ram_dout;
      if (w_done_d && !r_gnt_we) r_d_dout <= ram_dout;
    end
  end

  assign a_dout   = r_a_dout;
  assign a_ack    = r_a_ack;
  assign b_dout   = r_b_dout;
  assign b_ack    = r_b_ack;
  assign d_dout   = r_d_dout;
  assign d_ack    = r_d_ack;
  assign ram_addr = r_ram_addr;
  assign ram_we   = r_ram_we;
  assign ram_din  = r_ram_din;
  assign ovr      = r_ovr;

endmodule

// File: tb/tb_ieeedrv_ram_arb.sv
// Bench for ieeedrv_ram_arb: synchronous RAM, transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, then randomized stress.
module tb_ieeedrv_ram_arb;
  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_din = '0;
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_din = '0;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_din = '0;
  logic [DW-1:0] a_dout, b_dout, d_dout, ram_din, ram_dout;
  logic          a_ack, b_ack, d_ack, ram_we, ovr;
  logic [AW-1:0] ram_addr;

  logic [DW-1:0] tb_mem [0:4095];
  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  ieeedrv_ram_arb #(.AW(AW), .DW(DW)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout), .b_ack(b_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_din(d_din), .d_dout(d_dout), .d_ack(d_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout), .ovr(ovr)
  );

  // Single-port synchronous RAM, read-first, one cycle of read latency.
  always @(posedge clk_sys) begin
    if (ram_we) tb_mem[ram_addr] <= ram_din;
    ram_dout <= tb_mem[ram_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [DW-1:0] m_mem [0:4095];
  logic          m_pend [2];
  logic          m_hwe [2];
  logic [AW-1:0] m_haddr [2];
  logic [DW-1:0] m_hdin [2];
  bit            m_busy;
  int            m_owner, m_gt;
  logic          m_owe;
  logic [AW-1:0] m_oaddr;
  logic [DW-1:0] m_odin, m_rdata;
  logic [2:0]    e_ack;
  logic [DW-1:0] e_dout [3];
  logic          e_we, e_ovr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din;
  int t = 0;
  bit lat_en = 0;
  int a_t = 0, b_t = 0, max_lat = 0, n_we = 0, n_dack = 0;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      tb_mem[i] = '0;
      m_mem[i]  = '0;
    end
  end

  // An access granted at edge g uses the RAM at g+1 and completes (ack, dout) at g+2.
  task automatic model_step();
    int done;
    int g;
    logic          rq [2];
    logic          rwe [2];
    logic [AW-1:0] rad [2];
    logic [DW-1:0] rdi [2];
    rq[0] = a_req; rwe[0] = a_we; rad[0] = a_addr; rdi[0] = a_din;
    rq[1] = b_req; rwe[1] = b_we; rad[1] = b_addr; rdi[1] = b_din;
    e_ack = '0;
    e_we  = 1'b0;
    if (!reset_n) begin
      m_pend[0] = 1'b0; m_pend[1] = 1'b0;
      m_busy = 0;
      e_addr = '0; e_din = '0; e_ovr = 1'b0;
      for (int i = 0; i < 3; i++) e_dout[i] = '0;
      return;
    end
    done = -1;
    g = -1;
    if (m_busy && t == m_gt + 1) begin
      m_rdata = m_mem[m_oaddr];
      if (m_owe) m_mem[m_oaddr] = m_odin;
    end
    if (m_busy && t == m_gt + 2) begin
      done = m_owner;
      m_busy = 0;
      e_ack[done] = 1'b1;
      if (!m_owe) e_dout[done] = m_rdata;
      if (done < 2) m_pend[done] = 1'b0;
    end
    if (!m_busy) begin
      if (m_pend[0]) g = 0;
      else if (m_pend[1]) g = 1;
      else if (d_req && done != 2) g = 2;
      if (g >= 0) begin
        m_busy = 1; m_gt = t; m_owner = g;
        if (g == 2) begin
          m_owe = d_we; m_oaddr = d_addr; m_odin = d_din;
        end else begin
          m_owe = m_hwe[g]; m_oaddr = m_haddr[g]; m_odin = m_hdin[g];
        end
        e_we = m_owe; e_addr = m_oaddr; e_din = m_odin;
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (rq[p]) begin
        if (m_pend[p]) e_ovr = 1'b1;
        else begin
          m_pend[p] = 1'b1; m_hwe[p] = rwe[p]; m_haddr[p] = rad[p]; m_hdin[p] = rdi[p];
        end
      end
    end
  endtask

  always @(posedge clk_sys) begin
    #1;
    t++;
    model_step();
    check("cycle", {15'b0, a_ack, b_ack, d_ack, ovr, ram_we, ram_addr, ram_din, a_dout, b_dout, d_dout},
          {15'b0, e_ack[0], e_ack[1], e_ack[2], e_ovr, e_we, e_addr, e_din, e_dout[0], e_dout[1], e_dout[2]});
    if (ram_we) n_we++;
    if (d_ack) n_dack++;
    if (lat_en) begin
      if (a_ack) begin
        check("a_latency_le7", 64'(t - a_t <= 7), 64'd1);
        if (t - a_t > max_lat) max_lat = t - a_t;
      end
      if (b_ack) begin
        check("b_latency_le7", 64'(t - b_t <= 7), 64'd1);
        if (t - b_t > max_lat) max_lat = t - b_t;
      end
      if (a_req) a_t = t;
      if (b_req) b_t = t;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic cycn(input int n);
    repeat (n) cyc();
  endtask

  task automatic a_strobe(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] din);
    a_req = 1'b1; a_we = we; a_addr = addr; a_din = din;
    cyc();
    a_req = 1'b0;
  endtask

  task automatic b_strobe(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] din);
    b_req = 1'b1; b_we = we; b_addr = addr; b_din = din;
    cyc();
    b_req = 1'b0;
  endtask

  task automatic wait_ack(input int port, output int k);
    k = 0;
    while (!(port == 0 ? a_ack : b_ack) && k < 20) begin
      cyc();
      k++;
    end
  endtask

  task automatic dma_run(input logic [AW-1:0] base, input int n, input logic we);
    logic [AW-1:0] ad;
    int k;
    for (int i = 0; i < n; i++) begin
      ad = base + AW'(i);
      d_req = 1'b1; d_we = we; d_addr = ad; d_din = ad[7:0] ^ 8'hC3;
      k = 0;
      do begin
        cyc();
        k++;
      end while (!d_ack && k < 40);
      check("dma_word_ack", 64'(d_ack), 64'd1);
    end
    d_req = 1'b0;
  endtask

  task automatic cpu_stress(input int port, input int n);
    for (int i = 0; i < n; i++) begin
      cycn(7 + int'($urandom_range(0, 3)));
      if (port == 0)
        a_strobe(1'($urandom_range(0, 1)), AW'($urandom_range(0, 4095)), DW'($urandom));
      else
        b_strobe(1'($urandom_range(0, 1)), AW'($urandom_range(0, 4095)), DW'($urandom));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k, cnt, da0, we0, t0;
    // Reset holds everything quiet even with a strobe present.
    reset_n = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 12'h123; a_din = 8'hEE;
    cycn(3);
    check("reset_quiet", {15'b0, a_ack, b_ack, d_ack, ovr, ram_we, ram_addr, ram_din, a_dout, b_dout, d_dout},
          64'd0);
    a_req = 1'b0;
    reset_n = 1'b1;
    cyc();

    // Write via A, read back via B; both take three cycles.
    a_strobe(1'b1, 12'h123, 8'h5A);
    wait_ack(0, k);
    check("a_wr_latency", 64'(k), 64'd3);
    b_strobe(1'b0, 12'h123, 8'h00);
    wait_ack(1, k);
    check("b_rd_latency", 64'(k), 64'd3);
    check("b_dout_5a", 64'(b_dout), 64'h5A);

    // Simultaneous A and B strobes: A first, B two cycles later.
    a_req = 1'b1; a_we = 1'b1; a_addr = 12'h010; a_din = 8'h11;
    b_req = 1'b1; b_we = 1'b0; b_addr = 12'h123;
    cyc();
    a_req = 1'b0; b_req = 1'b0;
    cyc();
    check("ab_first_addr", 64'(ram_addr), 64'h010);
    check("ab_first_we", 64'(ram_we), 64'd1);
    cycn(2);
    check("ab_a_ack_n3", 64'({a_ack, b_ack}), 64'b10);
    cycn(2);
    check("ab_b_ack_n5", 64'({a_ack, b_ack}), 64'b01);
    check("ab_b_dout", 64'(b_dout), 64'h5A);

    // DMA streaming with an A write injected during the third DMA word.
    da0 = n_dack;
    we0 = n_we;
    fork
      dma_run(12'h200, 6, 1'b1);
      begin
        int kk;
        for (int j = 0; j < 2; j++) begin
          kk = 0;
          do begin
            cyc();
            kk++;
          end while (!d_ack && kk < 40);
        end
        cyc();
        a_strobe(1'b1, 12'h2F0, 8'h3C);
        kk = 0;
        while (!a_ack && kk < 20) begin
          cyc();
          kk++;
        end
        check("a_served_after_word3", 64'(n_dack - da0), 64'd3);
      end
    join
    check("dma_acks", 64'(n_dack - da0), 64'd6);
    check("we_pulses", 64'(n_we - we0), 64'd7);
    cycn(3);

    // Strobe repeated one cycle later: overrun, single ack, first data kept.
    a_req = 1'b1; a_we = 1'b1; a_addr = 12'h300; a_din = 8'h77;
    cyc();
    a_din = 8'h99;
    cyc();
    a_req = 1'b0;
    cnt = 0;
    for (int j = 0; j < 8; j++) begin
      cyc();
      if (a_ack) cnt++;
    end
    check("ovr_single_ack", 64'(cnt), 64'd1);
    check("ovr_set", 64'(ovr), 64'd1);
    b_strobe(1'b0, 12'h300, 8'h00);
    wait_ack(1, k);
    check("ovr_ram_first_data", 64'(b_dout), 64'h77);
    check("ovr_sticky", 64'(ovr), 64'd1);

    // Reset during the RUN cycle of a write: no write, no ack.
    a_strobe(1'b1, 12'h400, 8'hFF);
    cyc();
    check("run_we_before_reset", 64'(ram_we), 64'd1);
    reset_n = 1'b0;
    #1;
    check("we_cleared_async", 64'(ram_we), 64'd0);
    cnt = 0;
    cyc();
    reset_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      cyc();
      if (a_ack) cnt++;
    end
    check("no_ack_after_reset", 64'(cnt), 64'd0);
    check("ovr_cleared_by_reset", 64'(ovr), 64'd0);
    b_strobe(1'b0, 12'h400, 8'h00);
    wait_ack(1, k);
    check("aborted_write_readback", 64'(b_dout), 64'h00);

    // Random stress.
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    lat_en = 1;
    fork
      cpu_stress(0, 1000);
      cpu_stress(1, 1000);
      begin
        t0 = t;
        dma_run(12'h800, 256, 1'b1);
        check("dma_bw_1_per_8", 64'(t - t0 <= 256 * 8), 64'd1);
        dma_run(12'h800, 32, 1'b0);
      end
    join
    cycn(8);
    lat_en = 0;
    check("stress_ovr_0", 64'(ovr), 64'd0);
    check("stress_max_lat", 64'(max_lat <= 7 && max_lat >= 3), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
